jk_exc_driver: RTL and testbench

Excitation sequencer that drives an external bank of WIDTH JK flip-flops (J/K/CE inputs, Q feedback) from word-level requests. It converts a target word or a toggle mask into per-bit J/K excitation, issues one clock-enable pulse, checks the bank's Q against the expected value, and reports completion or error. It is the control side of the JK storage element: it generates the J/K stimulus from a desired state, where a JK flip-flop generates state from J/K stimulus.

---
 rtl/jk_exc_driver_if.sv | 31 +++
 rtl/jk_exc_driver.sv | 120 ++++++++++++
 tb/tb_jk_exc_driver.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/jk_exc_driver_if.sv
// jk_exc_driver_if: request handshake plus JK bank excitation/feedback bundle.
// Revision: 1.0
`default_nettype none

interface jk_exc_driver_if #(
    parameter int WIDTH = 8
);
    logic             req_v;
    logic             req_rdy;
    logic             mode;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             ce;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output req_v, mode, target, q_fb,
        input  req_rdy, j, k, ce, busy, done, err
    );

    modport slave (
        input  req_v, mode, target, q_fb,
        output req_rdy, j, k, ce, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/jk_exc_driver.sv
// jk_exc_driver: drives a JK flip-flop bank toward a word, verifies Q, reports DONE/ERR.
// Revision: 1.0 -- optional retry path selected by JK_DRV_RETRY_EN.
`default_nettype none

module jk_exc_driver #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    jk_exc_driver_if.slave       bus
);
    if (WIDTH < 1 || MAX_RETRY < 0) begin : g_bad_cfg
        $error("jk_exc_driver: WIDTH must be >= 1 and MAX_RETRY >= 0");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] exp_word;
    logic [WIDTH-1:0] j_q;
    logic [WIDTH-1:0] k_q;
    logic             ce_q;
    logic             done_q;
    logic             err_q;
    logic             mismatch;

`ifdef JK_DRV_RETRY_EN
    localparam int RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RCW-1:0] RETRY_INIT = RCW'(MAX_RETRY);
    logic [RCW-1:0] retry_cnt;
`endif

    assign mismatch    = (bus.q_fb != exp_word);
    assign bus.req_rdy = (state == IDLE) && !rst;
    assign bus.busy    = (state != IDLE);
    assign bus.j       = j_q;
    assign bus.k       = k_q;
    assign bus.ce      = ce_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            exp_word <= '0;
            j_q      <= '0;
            k_q      <= '0;
            ce_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef JK_DRV_RETRY_EN
            retry_cnt <= RETRY_INIT;
`endif
        end else begin
            // Excitation and status are pulses: cleared unless a transition sets them.
            j_q    <= '0;
            k_q    <= '0;
            ce_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_v) begin
                        if (bus.mode) begin
                            exp_word <= bus.q_fb ^ bus.target;
                            j_q      <= bus.target;
                            k_q      <= bus.target;
                        end else begin
                            exp_word <= bus.target;
                            j_q      <= bus.target & ~bus.q_fb;
                            k_q      <= ~bus.target & bus.q_fb;
                        end
                        ce_q  <= 1'b1;
                        state <= DRIVE;
`ifdef JK_DRV_RETRY_EN
                        retry_cnt <= RETRY_INIT;
`endif
                    end
                end
                DRIVE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (!mismatch) begin
                        done_q <= 1'b1;
                        state  <= FIN;
                    end
`ifdef JK_DRV_RETRY_EN
                    // Retries always steer toward the expected word with load excitation.
                    else if (retry_cnt != '0) begin
                        retry_cnt <= retry_cnt - 1'b1;
                        j_q       <= exp_word & ~bus.q_fb;
                        k_q       <= ~exp_word & bus.q_fb;
                        ce_q      <= 1'b1;
                        state     <= DRIVE;
                    end
`endif
                    else begin
                        err_q <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_jk_exc_driver.sv
// tb_jk_exc_driver: directed and random requests against a JK bank model and outcome model.
// Revision: 1.0
`default_nettype none

module tb_jk_exc_driver;
    localparam int W    = 8;
    localparam int MAXR = 3;
`ifdef JK_DRV_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_exc_driver_if #(.WIDTH(W)) bus ();

    jk_exc_driver #(.WIDTH(W), .MAX_RETRY(MAXR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External JK bank: frozen bits ignore excitation (models stuck cells).
    logic [W-1:0] bank_q;
    logic [W-1:0] frz = '0;
    logic [W-1:0] preload_val = '0;
    logic         preload_req = 1'b0;
    assign bus.q_fb = bank_q;

    always @(posedge clk) begin
        if (preload_req) begin
            bank_q <= preload_val;
        end else if (bus.ce) begin
            for (int i = 0; i < W; i++) begin
                if (!frz[i]) begin
                    case ({bus.j[i], bus.k[i]})
                        2'b10:   bank_q[i] <= 1'b1;
                        2'b01:   bank_q[i] <= 1'b0;
                        2'b11:   bank_q[i] <= ~bank_q[i];
                        default: bank_q[i] <= bank_q[i];
                    endcase
                end
            end
        end
    end

    int accepts = 0;
    always @(posedge clk) if (bus.req_v && bus.req_rdy) accepts++;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [W-1:0] v);
        preload_val = v;
        preload_req = 1'b1;
        @(posedge clk); #1;
        preload_req = 1'b0;
    endtask

    // Issue one request and follow it to completion; expectations come from
    // reachability of the expected word given the frozen bank cells.
    task automatic run_req(input bit mode, input logic [W-1:0] target,
                           input bit transient, input bit hold);
        logic [W-1:0] q0, expw, ej, ek;
        bit   reach, success;
        int   attempts, ces, endc, acc0;
        q0      = bank_q;
        expw    = mode ? (q0 ^ target) : target;
        reach   = (((expw ^ q0) & frz) == '0);
        if (reach) begin
            attempts = 1;
            success  = 1'b1;
        end else if (transient) begin
            attempts = RETRY ? 2 : 1;
            success  = RETRY;
        end else begin
            attempts = RETRY ? 1 + MAXR : 1;
            success  = 1'b0;
        end
        chk("rdy_before_req", {31'd0, bus.req_rdy}, 32'd1);
        acc0       = accepts;
        bus.req_v  = 1'b1;
        bus.mode   = mode;
        bus.target = target;
        @(posedge clk); #1;
        if (!hold) bus.req_v = 1'b0;
        ces  = 0;
        endc = 0;
        for (int c = 1; c <= 25 && endc == 0; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (transient && ces >= 1) frz = '0;
            if (c == 1) begin
                chk("ce_cycle1", {31'd0, bus.ce}, 32'd1);
                chk("busy_cycle1", {31'd0, bus.busy}, 32'd1);
            end
            if (bus.ce) begin
                ces++;
                if (ces == 1 && mode) begin
                    ej = target;
                    ek = target;
                end else begin
                    ej = expw & ~bank_q;
                    ek = ~expw & bank_q;
                end
                chk("j_drive", {24'd0, bus.j}, {24'd0, ej});
                chk("k_drive", {24'd0, bus.k}, {24'd0, ek});
            end
            if (bus.done || bus.err) endc = c;
        end
        chk("end_cycle", endc, 1 + 2 * attempts);
        chk("ce_pulses", ces, attempts);
        chk("done_flag", {31'd0, bus.done}, {31'd0, success});
        chk("err_flag", {31'd0, bus.err}, {31'd0, !success});
        if (success) chk("bank_final", {24'd0, bank_q}, {24'd0, expw});
        @(posedge clk); #1;
        chk("rdy_after", {31'd0, bus.req_rdy}, 32'd1);
        chk("pulse_cleared", {30'd0, bus.done, bus.err}, 32'd0);
        if (hold) bus.req_v = 1'b0;
        chk("accept_count", accepts - acc0, 1);
    endtask

    initial begin
        bus.req_v  = 1'b0;
        bus.mode   = 1'b0;
        bus.target = '0;
        @(posedge clk); #1;
        chk("rst_j", {24'd0, bus.j}, 32'd0);
        chk("rst_k", {24'd0, bus.k}, 32'd0);
        chk("rst_flags", {27'd0, bus.ce, bus.busy, bus.done, bus.err, bus.req_rdy}, 32'd0);
        preload(8'h00);
        rst = 1'b0;
        #1;
        chk("rdy_post_rst", {31'd0, bus.req_rdy}, 32'd1);

        run_req(1'b0, 8'hA5, 1'b0, 1'b0);
        preload(8'hF0);
        run_req(1'b0, 8'h3C, 1'b0, 1'b0);
        preload(8'h55);
        run_req(1'b1, 8'h0F, 1'b0, 1'b0);
        preload(8'h5A);
        run_req(1'b0, 8'h5A, 1'b0, 1'b0);

        preload(8'h00);
        frz = 8'h01;
        run_req(1'b0, 8'h01, 1'b0, 1'b0);
        frz = '0;

        preload(8'h00);
        frz = 8'h08;
        run_req(1'b0, 8'h08, 1'b1, 1'b0);
        frz = '0;

        preload(8'h81);
        run_req(1'b0, 8'h33, 1'b0, 1'b1);

        // Reset during DRIVE abandons the request.
        preload(8'h00);
        bus.req_v  = 1'b1;
        bus.mode   = 1'b0;
        bus.target = 8'hFF;
        @(posedge clk); #1;
        bus.req_v = 1'b0;
        chk("ce_before_rst", {31'd0, bus.ce}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ce_drop_rst", {31'd0, bus.ce}, 32'd0);
        chk("busy_rst", {30'd0, bus.busy, bus.req_rdy}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("no_pulse_in_rst", {30'd0, bus.done, bus.err}, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rdy_after_release", {31'd0, bus.req_rdy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_pulse_after_rst", {30'd0, bus.done, bus.err}, 32'd0);
        end

        for (int n = 0; n < 16; n++) begin
            preload(W'($urandom));
            run_req(1'($urandom), W'($urandom), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
